// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package uart_pkg;

  // Register select values taken from data_addr[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  // STATUS register bit positions
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 5;

  // Transmit frame sequencer states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Down-counter load value for one bit period; a divisor of 0 behaves as 1
  function automatic logic [15:0] reload_cnt(input logic [15:0] div);
    if (div == 16'd0) begin
      return 16'd0;
    end else begin
      return div - 16'd1;
    end
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU data-memory port as seen by a memory-mapped peripheral.
interface uart_tx_mmio_if;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        hit;

  modport master (
    output data_read, data_write, data_addr, data_in,
    input  data_out, hit
  );

  modport slave (
    input  data_read, data_write, data_addr, data_in,
    output data_out, hit
  );
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is accepted
// only if a pop happens on the same edge, which frees the slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_s, empty_s, push_ok_s, pop_ok_s;

  assign full_s    = (count_q == CW'(DEPTH));
  assign empty_s   = (count_q == {CW{1'b0}});
  assign pop_ok_s  = pop & ~empty_s;
  assign push_ok_s = push & (~full_s | pop_ok_s);

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_q;

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIV register window,
// byte FIFO, and a baud-timed frame sequencer driving a registered tx line.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_mmio_if.slave   bus,
  output logic            tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Register-window decode
  logic        hit_s;
  logic [1:0]  sel_s;
  logic        wr_txdata_s, wr_status_s, wr_div_s;
  logic [31:0] status_s;
  logic [31:0] rdata_s;

  // FIFO interface
  logic          fifo_pop_s;
  logic [7:0]    fifo_rdata_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;

  // Control registers
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;

  // Frame sequencer
  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_end_s;

  // Address bits [1:0] and the upper store-data half carry no meaning here
  logic unused_s;
  assign unused_s = ^{bus.data_addr[1:0], bus.data_in[31:16]};

  assign hit_s     = (bus.data_addr[31:4] == BASE_ADDR[31:4]);
  assign sel_s     = bus.data_addr[3:2];
  assign bus.hit   = hit_s;
  assign bit_end_s = (cnt_q == 16'd0);
  assign tx        = tx_q;

  // Decode store strobes to individual register writes
  always_comb begin
    wr_txdata_s = 1'b0;
    wr_status_s = 1'b0;
    wr_div_s    = 1'b0;
    if (hit_s && bus.data_write) begin
      case (sel_s)
        REG_TXDATA: wr_txdata_s = 1'b1;
        REG_STATUS: wr_status_s = 1'b1;
        REG_DIV:    wr_div_s    = 1'b1;
        default:    wr_txdata_s = 1'b0;
      endcase
    end else begin
      wr_txdata_s = 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (wr_txdata_s),
    .wdata (bus.data_in[7:0]),
    .pop   (fifo_pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Assemble STATUS from pre-edge state
  always_comb begin
    status_s = 32'd0;
    status_s[STAT_FULL]  = fifo_full_s;
    status_s[STAT_EMPTY] = fifo_empty_s;
    status_s[STAT_BUSY]  = (state_q != TX_IDLE);
    status_s[STAT_OVF]   = ovf_q;
    status_s[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count_s);
  end

  // Combinational read mux so a load completes in the same cycle
  always_comb begin
    rdata_s = 32'd0;
    if (hit_s && bus.data_read) begin
      case (sel_s)
        REG_STATUS: rdata_s = status_s;
        REG_DIV:    rdata_s = {16'd0, div_q};
        default:    rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign bus.data_out = rdata_s;

  // Divisor and sticky overflow next-state
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_div_s) begin
      div_d = bus.data_in[15:0];
    end else begin
      div_d = div_q;
    end
    if (wr_txdata_s && fifo_full_s && !fifo_pop_s) begin
      ovf_d = 1'b1;
    end else if (wr_status_s && bus.data_in[STAT_OVF]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Frame sequencer: next state, baud counter, bit index and shift register
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    fifo_pop_s = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          shift_d    = fifo_rdata_s;
          cnt_d      = reload_cnt(div_q);
          state_d    = TX_START;
        end else begin
          state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (bit_end_s) begin
          idx_d   = 3'd0;
          cnt_d   = reload_cnt(div_q);
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (bit_end_s) begin
          cnt_d = reload_cnt(div_q);
          if (idx_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (bit_end_s) begin
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            shift_d    = fifo_rdata_s;
            cnt_d      = reload_cnt(div_q);
            state_d    = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // Line level follows the state being entered so tx changes with it
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers; reset returns the line high immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= DEFAULT_DIV;
      ovf_q   <= 1'b0;
      state_q <= TX_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed register checks plus
// randomized frame streams compared against a line-level reference model.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic clk;
  logic rst;
  logic tx;
  int   n_tests;
  int   n_fail;

  uart_tx_mmio_if bus_if ();

  uart_tx_mmio #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .tx  (tx)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Single store; called just after a falling edge, returns after the next one
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.data_write = 1'b1;
    bus_if.data_addr  = a;
    bus_if.data_in    = d;
    @(negedge clk);
    bus_if.data_write = 1'b0;
  endtask

  // Combinational load, no clock consumed
  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus_if.data_read = 1'b1;
    bus_if.data_addr = a;
    #1;
    d = bus_if.data_out;
    h = bus_if.hit;
    bus_if.data_read = 1'b0;
  endtask

  // Store nb bytes on consecutive edges and compare tx and STATUS every cycle
  // against the frame stream and FIFO occupancy derived from the byte list.
  task automatic run_frames(input logic [15:0] div_w, input int nb,
                            input logic [7:0] b [4], input logic [3:0] lo);
    logic [31:0] rd;
    logic        h;
    logic        stream [$];
    int          eff, frame, total, t, popped, pushed, cnt;
    logic [31:0] exp_st;
    logic        exp_tx;
    logic [31:0] upper;

    upper = $urandom();
    bus_wr(BASE + 32'd8, {upper[31:16], div_w});
    bus_rd(BASE + 32'd8, rd, h);
    check_eq("div_readback", rd, {16'd0, div_w});

    eff   = (div_w == 16'd0) ? 1 : int'(div_w);
    frame = 10 * eff;
    total = nb * frame;
    stream.delete();
    for (int j = 0; j < nb; j++) begin
      for (int k = 0; k < 10; k++) begin
        for (int r = 0; r < eff; r++) begin
          if (k == 0) stream.push_back(1'b0);
          else if (k == 9) stream.push_back(1'b1);
          else stream.push_back(b[j][k-1]);
        end
      end
    end

    upper = $urandom();
    bus_if.data_write = 1'b1;
    bus_if.data_addr  = BASE | {28'd0, lo};
    bus_if.data_in    = {upper[31:8], b[0]};
    for (int c = 1; c <= total + 4; c++) begin
      @(negedge clk);
      t = c - 1;
      exp_tx = (t >= 1 && t <= total) ? stream[t-1] : 1'b1;
      check_eq("tx_line", {31'd0, tx}, {31'd0, exp_tx});
      if (bus_if.data_read) begin
        popped = 0;
        for (int j = 0; j < nb; j++) if (1 + j * frame <= t) popped++;
        pushed = (t + 1 < nb) ? t + 1 : nb;
        cnt    = pushed - popped;
        exp_st = 32'd0;
        exp_st[0] = (cnt == 8);
        exp_st[1] = (cnt == 0);
        exp_st[2] = (t >= 1 && t <= total);
        exp_st[8:4] = 5'(cnt);
        check_eq("status_live", bus_if.data_out, exp_st);
      end
      if (c < nb) begin
        upper = $urandom();
        bus_if.data_in = {upper[31:8], b[c]};
      end else if (c == nb) begin
        bus_if.data_write = 1'b0;
        bus_if.data_read  = 1'b1;
        bus_if.data_addr  = BASE + 32'd4;
      end
    end
    bus_if.data_read = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        h;
    logic [7:0]  bytes [4];
    int          mc;
    bit          movf;
    logic [31:0] exp_st;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus_if.data_read  = 1'b0;
    bus_if.data_write = 1'b0;
    bus_if.data_addr  = 32'd0;
    bus_if.data_in    = 32'd0;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    bus_rd(BASE + 32'd4, rd, h);
    check_eq("rst_status", rd, 32'h0000_0002);
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    bus_rd(BASE + 32'd8, rd, h);
    check_eq("rst_div", rd, 32'd868);

    // Address decode
    bus_rd(BASE + 32'd16, rd, h);
    check_eq("hit_outside", {31'd0, h}, 32'd0);
    check_eq("dout_outside", rd, 32'd0);
    bus_rd(BASE + 32'd12, rd, h);
    check_eq("hit_reserved", {31'd0, h}, 32'd1);
    check_eq("dout_reserved", rd, 32'd0);
    bus_rd(BASE, rd, h);
    check_eq("dout_txdata", rd, 32'd0);
    bus_if.data_addr = BASE + 32'd4;
    #1;
    check_eq("dout_noread", bus_if.data_out, 32'd0);
    @(negedge clk);

    // Directed 0xA5 frame at DIV=4
    bytes[0] = 8'hA5; bytes[1] = 8'h00; bytes[2] = 8'h00; bytes[3] = 8'h00;
    run_frames(16'd4, 1, bytes, 4'd0);

    // Store with low address bits set still hits TXDATA
    bytes[0] = 8'h3C;
    run_frames(16'd3, 1, bytes, 4'd2);

    // Back-to-back three-byte stream at DIV=2
    bytes[0] = 8'h11; bytes[1] = 8'hF0; bytes[2] = 8'h81;
    run_frames(16'd2, 3, bytes, 4'd0);

    // Randomized streams, including DIV=0
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) bytes[j] = 8'($urandom());
      run_frames(16'($urandom_range(0, 6)), $urandom_range(1, 4), bytes, 4'($urandom_range(0, 3)));
    end

    // Overflow: ten back-to-back stores while the first frame is slow
    bus_wr(BASE + 32'd8, 32'd100);
    for (int k = 0; k < 10; k++) begin
      bus_if.data_write = 1'b1;
      bus_if.data_addr  = BASE;
      bus_if.data_in    = (k == 0) ? 32'd0 : $urandom();
      @(negedge clk);
    end
    bus_if.data_write = 1'b0;
    mc = 0;
    movf = 1'b0;
    for (int e = 0; e < 10; e++) begin
      if (mc == 8 && e != 1) movf = 1'b1;
      else mc++;
      if (e == 1) mc--;
    end
    exp_st = 32'd0;
    exp_st[0] = (mc == 8);
    exp_st[1] = (mc == 0);
    exp_st[2] = 1'b1;
    exp_st[3] = movf;
    exp_st[8:4] = 5'(mc);
    bus_rd(BASE + 32'd4, rd, h);
    check_eq("ovf_status", rd, exp_st);
    bus_wr(BASE + 32'd4, 32'd0);
    bus_rd(BASE + 32'd4, rd, h);
    check_eq("ovf_hold", rd, exp_st);
    bus_wr(BASE + 32'd4, 32'd8);
    exp_st[3] = 1'b0;
    bus_rd(BASE + 32'd4, rd, h);
    check_eq("ovf_clear", rd, exp_st);

    // Reset in the middle of the first data bit of byte 0x00
    repeat (150) @(negedge clk);
    #1;
    check_eq("tx_data_bit", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("tx_async_rst", {31'd0, tx}, 32'd1);
    bus_rd(BASE + 32'd4, rd, h);
    check_eq("status_in_rst", rd, 32'h0000_0002);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus_rd(BASE + 32'd4, rd, h);
    check_eq("status_after_rst", rd, 32'h0000_0002);
    bus_rd(BASE + 32'd8, rd, h);
    check_eq("div_after_rst", rd, 32'd868);
    check_eq("tx_after_rst", {31'd0, tx}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
